// File: rtl/boot_loader.sv
// Framed word-stream loader driving the IM/DM preload buses with single-cycle write strobes.
// Optional trailer checksum per block is enabled with `define BOOT_LOADER_CHECKSUM_EN.
module boot_loader #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              loading,
  output logic              im_cen_load,
  output logic              im_wen_load,
  output logic              im_oen_load,
  output logic [ADDR_W-1:0] im_addr_load,
  output logic [DATA_W-1:0] im_datain_load,
  output logic              dm_cen_load,
  output logic              dm_wen_load,
  output logic              dm_oen_load,
  output logic [ADDR_W-1:0] dm_addr_load,
  output logic [DATA_W-1:0] dm_datain_load,
  output logic              done,
  output logic              err
);

  localparam int unsigned LenW = 12;

`ifdef BOOT_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StHeader, StData, StCheck, StDone} state_e;
  logic [DATA_W-1:0] sum_q;
`else
  typedef enum logic [2:0] {StIdle, StHeader, StData, StDone} state_e;
`endif

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, im_addr_q, dm_addr_q;
  logic [LenW-1:0]   rem_q;
  logic [DATA_W-1:0] im_data_q, dm_data_q;
  logic              tgt_q, last_q, err_q, done_q, im_wen_q, dm_wen_q;

  logic              sess_start, hdr_load, data_take, set_err;
  logic              hdr_tgt, hdr_last;
  logic [ADDR_W-1:0] hdr_base;
  logic [LenW-1:0]   hdr_len;

  assign hdr_tgt  = in_data[31];
  assign hdr_last = in_data[30];
  assign hdr_base = in_data[16 +: ADDR_W];
  assign hdr_len  = in_data[11:0];

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    loading    = 1'b0;
    sess_start = 1'b0;
    hdr_load   = 1'b0;
    data_take  = 1'b0;
    set_err    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          sess_start = 1'b1;
          state_d    = StHeader;
        end
      end
      StHeader: begin
        in_ready = 1'b1;
        loading  = 1'b1;
        if (in_valid) begin
          if (32'(hdr_len) > DEPTH) begin
            set_err = 1'b1;
            state_d = StDone;
          end else if (hdr_len == '0) begin
            // Empty block: carries no data and no trailer.
            if (hdr_last) state_d = StDone;
          end else begin
            hdr_load = 1'b1;
            state_d  = StData;
          end
        end
      end
      StData: begin
        in_ready = 1'b1;
        loading  = 1'b1;
        if (in_valid) begin
          data_take = 1'b1;
          if (rem_q == LenW'(1)) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = last_q ? StDone : StHeader;
`endif
          end
        end
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      StCheck: begin
        in_ready = 1'b1;
        loading  = 1'b1;
        if (in_valid) begin
          if (in_data != sum_q) begin
            set_err = 1'b1;
            state_d = StDone;
          end else begin
            state_d = last_q ? StDone : StHeader;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      rem_q     <= '0;
      tgt_q     <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      im_wen_q  <= 1'b1;
      dm_wen_q  <= 1'b1;
      im_addr_q <= '0;
      dm_addr_q <= '0;
      im_data_q <= '0;
      dm_data_q <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      im_wen_q <= 1'b1;
      dm_wen_q <= 1'b1;
      done_q   <= (state_d == StDone) && (state_q != StDone);
      if (sess_start)   err_q <= 1'b0;
      else if (set_err) err_q <= 1'b1;
      if (hdr_load) begin
        addr_q <= hdr_base;
        rem_q  <= hdr_len;
        tgt_q  <= hdr_tgt;
        last_q <= hdr_last;
`ifdef BOOT_LOADER_CHECKSUM_EN
        sum_q  <= '0;
`endif
      end
      if (data_take) begin
        addr_q <= (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
        rem_q  <= rem_q - LenW'(1);
`ifdef BOOT_LOADER_CHECKSUM_EN
        sum_q  <= sum_q + in_data;
`endif
        if (tgt_q) begin
          dm_wen_q  <= 1'b0;
          dm_addr_q <= addr_q;
          dm_data_q <= in_data;
        end else begin
          im_wen_q  <= 1'b0;
          im_addr_q <= addr_q;
          im_data_q <= in_data;
        end
      end
    end
  end

  assign im_cen_load    = ~loading;
  assign dm_cen_load    = ~loading;
  assign im_oen_load    = 1'b1;
  assign dm_oen_load    = 1'b1;
  assign im_wen_load    = im_wen_q;
  assign dm_wen_load    = dm_wen_q;
  assign im_addr_load   = im_addr_q;
  assign dm_addr_load   = dm_addr_q;
  assign im_datain_load = im_data_q;
  assign dm_datain_load = dm_data_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed sessions with random payloads, compared
// against a write-list model built from the block framing rules.
module tb_boot_loader;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DEPTH  = 2048;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready, loading, done, err;
  logic              im_cen_load, im_wen_load, im_oen_load;
  logic              dm_cen_load, dm_wen_load, dm_oen_load;
  logic [ADDR_W-1:0] im_addr_load, dm_addr_load;
  logic [DATA_W-1:0] im_datain_load, dm_datain_load;

  boot_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .loading(loading),
    .im_cen_load(im_cen_load), .im_wen_load(im_wen_load), .im_oen_load(im_oen_load),
    .im_addr_load(im_addr_load), .im_datain_load(im_datain_load),
    .dm_cen_load(dm_cen_load), .dm_wen_load(dm_wen_load), .dm_oen_load(dm_oen_load),
    .dm_addr_load(dm_addr_load), .dm_datain_load(dm_datain_load),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int gap_max = 0;
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] payload[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory-side observer: every low wen cycle is one write.
  always @(negedge clk) begin
    if (!im_wen_load) obs_q.push_back({20'd0, 1'b0, im_addr_load, im_datain_load});
    if (!dm_wen_load) obs_q.push_back({20'd0, 1'b1, dm_addr_load, dm_datain_load});
    if (done) done_cnt++;
    chk("ctl_invariant",
        {im_cen_load, dm_cen_load, im_oen_load, dm_oen_load, im_wen_load | dm_wen_load},
        {!loading, !loading, 1'b1, 1'b1, 1'b1});
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge right after the word is taken.
  task automatic send_word(input logic [31:0] w);
    int n;
    int g;
    g = (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0));
    if (g > 0) begin
      in_valid = 1'b0;
      repeat (g) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    @(negedge clk);
  endtask

  task automatic send_block(input logic tgt, input logic last, input int base);
    logic [10:0] b;
    logic [11:0] l;
    logic [31:0] sum;
    b   = base[10:0];
    l   = 12'(payload.size());
    sum = '0;
    send_word({tgt, last, 3'b000, b, 4'b0000, l});
    foreach (payload[i]) begin
      exp_q.push_back({20'd0, tgt, ADDR_W'((base + i) % DEPTH), payload[i]});
      sum += payload[i];
      send_word(payload[i]);
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    send_word(sum);
`endif
  endtask

  task automatic cmp_writes(input string tag);
    chk(tag, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) chk(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int d0;
    int base;
    logic [31:0] a, bw, s;

    // Reset values
    @(negedge clk);
    chk("rst_status", {in_ready, loading, done, err}, 4'b0000);
    chk("rst_ctl", {im_cen_load, im_wen_load, im_oen_load, dm_cen_load, dm_wen_load,
                    dm_oen_load}, 6'b111111);
    chk("rst_bus", {im_addr_load, im_datain_load, dm_addr_load, dm_datain_load}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ready", {in_ready, loading}, 2'b00);

    // Basic two-block load, back-to-back words
    d0 = done_cnt;
    pulse_start();
    chk("start_latency", {loading, in_ready, err}, 3'b110);
    payload = '{32'h11, 32'h22, 32'h33};
    send_block(1'b0, 1'b0, 0);
    payload = '{32'hAA, 32'hBB};
    send_block(1'b1, 1'b1, 5);
    chk("basic_done", {done, loading}, 2'b10);
`ifndef BOOT_LOADER_CHECKSUM_EN
    chk("basic_last_strobe", {dm_wen_load, dm_addr_load, dm_datain_load},
        {1'b0, 11'd6, 32'hBB});
`endif
    in_valid = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("basic_done_cnt", done_cnt - d0, 1);
    cmp_writes("basic_writes");

    // Address wrap at the top of memory
    pulse_start();
    payload = '{32'd1, 32'd2};
    send_block(1'b1, 1'b1, 2047);
    chk("wrap_done", done, 1);
    in_valid = 1'b0;
    @(negedge clk);
    cmp_writes("wrap_writes");

    // in_valid 1-0-0-1 gap inside a block
    pulse_start();
    a  = $urandom;
    bw = $urandom;
    send_word({1'b0, 1'b1, 3'b000, 11'h3F0, 4'b0000, 12'd2});
    send_word(a);
    exp_q.push_back({20'd0, 1'b0, 11'h3F0, a});
    in_valid = 1'b0;
    @(negedge clk);
    chk("gap_no_strobe", {im_wen_load, dm_wen_load}, 2'b11);
    @(negedge clk);
    chk("gap_no_strobe", {im_wen_load, dm_wen_load}, 2'b11);
    send_word(bw);
    exp_q.push_back({20'd0, 1'b0, 11'h3F1, bw});
`ifdef BOOT_LOADER_CHECKSUM_EN
    send_word(a + bw);
`endif
    chk("gap_done", done, 1);
    in_valid = 1'b0;
    @(negedge clk);
    cmp_writes("gap_writes");

    // Random multi-block session with random gaps and an ignored busy start
    gap_max = 2;
    d0 = done_cnt;
    pulse_start();
    for (int blk = 0; blk < 4; blk++) begin
      payload.delete();
      for (int k = 0; k < int'($urandom_range(6, 1)); k++) payload.push_back($urandom);
      base = int'($urandom_range(DEPTH - 1, 0));
      send_block(1'($urandom), blk == 3, base);
      if (blk == 1) begin
        in_valid = 1'b0;
        pulse_start();
        chk("busy_start_ignored", {loading, err, done}, 3'b100);
      end
    end
    gap_max = 0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rand_done_cnt", done_cnt - d0, 1);
    cmp_writes("rand_writes");

    // Zero-length blocks: no strobes, no trailer
    pulse_start();
    send_word({1'b0, 1'b0, 3'b000, 11'd9, 4'b0000, 12'd0});
    chk("zero_len_stay", {loading, in_ready, done}, 3'b110);
    send_word({1'b1, 1'b1, 3'b000, 11'd9, 4'b0000, 12'd0});
    chk("zero_len_done", {loading, done, err}, 3'b010);
    in_valid = 1'b0;
    @(negedge clk);
    cmp_writes("zero_len_writes");

    // Length above DEPTH
    pulse_start();
    send_word({1'b0, 1'b1, 3'b000, 11'd0, 4'b0000, 12'h801});
    chk("bad_len", {err, done, loading}, 3'b110);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("err_sticky", {err, done}, 2'b10);
    cmp_writes("bad_len_writes");
    pulse_start();
    chk("err_cleared", {err, loading}, 2'b01);

    // Reset mid-block after 2 of 4 words (session already open)
    a  = $urandom;
    bw = $urandom;
    send_word({1'b0, 1'b0, 3'b000, 11'h020, 4'b0000, 12'd4});
    send_word(a);
    send_word(bw);
    exp_q.push_back({20'd0, 1'b0, 11'h020, a});
    exp_q.push_back({20'd0, 1'b0, 11'h021, bw});
    #1 rst = 1'b1;
    #1;
    chk("rst_async_status", {in_ready, loading, done, err}, 4'b0000);
    chk("rst_async_ctl", {im_cen_load, im_wen_load, dm_cen_load, dm_wen_load}, 4'b1111);
    chk("rst_async_bus", {im_addr_load, im_datain_load}, 0);
    in_data = $urandom;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", {in_ready, loading}, 2'b00);
    in_valid = 1'b0;
    cmp_writes("rst_writes");

`ifdef BOOT_LOADER_CHECKSUM_EN
    // Wrong trailer
    pulse_start();
    a  = $urandom;
    bw = $urandom;
    s  = a + bw + 32'd1;
    send_word({1'b0, 1'b1, 3'b000, 11'd100, 4'b0000, 12'd2});
    send_word(a);
    send_word(bw);
    exp_q.push_back({20'd0, 1'b0, 11'd100, a});
    exp_q.push_back({20'd0, 1'b0, 11'd101, bw});
    send_word(s);
    chk("cksum_bad", {err, done, loading}, 3'b110);
    in_valid = 1'b0;
    @(negedge clk);
    cmp_writes("cksum_writes");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
